gray_decode_arbiter: RTL and testbench

Shared Gray-to-binary decode engine with a round-robin arbiter in front of it. Up to NREQ requesters present Gray-coded words over valid/ready handshakes. The block grants one requester at a time and decodes its word bit-serially, MSB first, one bit per clock. It returns the binary result, tagged with the requester index, on a single valid/ready output port. It sits between Gray-coded sources (position encoders, async-FIFO pointers) and binary consumers, so one decoder serves all of them.

---
 rtl/gray_decode_arbiter.sv | 150 +++++++++++++++
 tb/tb_gray_decode_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/gray_decode_arbiter.sv
// gray_decode_arbiter: round-robin arbiter feeding one shared Gray-to-binary
// decoder. The default build decodes bit-serially, MSB first, one bit per clock.
// Defining GRAY_DECODE_FAST_EN removes CONV and decodes the whole word on the
// accept edge.
module gray_decode_arbiter #(
  parameter int  WIDTH = 4,
  parameter int  NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_gray,
  output logic [NREQ-1:0]       req_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_bin,
  output logic [IDW-1:0]        out_id,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic             out_valid_q, out_valid_d;

  logic             found;
  logic [IDW-1:0]   gidx;
  logic [NREQ-1:0]  gnt;
  logic [WIDTH-1:0] gword;
  int               idx;

`ifdef GRAY_DECODE_FAST_EN
  // Whole-word decode: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
`else
  // cnt only ever holds WIDTH-2 down to 0.
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH-1) : 1;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  int               ci;
`endif

  // Round-robin grant: first valid requester at or after ptr, only while IDLE.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    gnt   = '0;
    idx   = 0;
    if (state_q == IDLE) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (int'(ptr_q) + k) % NREQ;
        if (!found && req_valid[idx]) begin
          found = 1'b1;
          gidx  = IDW'(idx);
        end
      end
    end
    if (found) gnt[gidx] = 1'b1;
    gword = req_gray[int'(gidx)*WIDTH +: WIDTH];
  end

  assign req_ready = gnt;
  assign out_valid = out_valid_q;
  assign out_bin   = bin_q;
  assign out_id    = id_q;
  assign busy      = (state_q != IDLE);

  // Next-state: accept in IDLE (ready follows valid, so a grant is an accept),
  // decode in CONV, hold the result in DONE until the consumer takes it.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    bin_d       = bin_q;
    out_valid_d = out_valid_q;
`ifndef GRAY_DECODE_FAST_EN
    cnt_d       = cnt_q;
    gray_d      = gray_q;
    ci          = int'(cnt_q);
`endif
    case (state_q)
      IDLE: if (found) begin
        id_d  = gidx;
        ptr_d = (int'(gidx) == NREQ-1) ? '0 : gidx + 1'b1;
`ifdef GRAY_DECODE_FAST_EN
        bin_d       = gray2bin(gword);
        out_valid_d = 1'b1;
        state_d     = DONE;
`else
        gray_d           = gword;
        bin_d            = '0;
        bin_d[WIDTH-1]   = gword[WIDTH-1];
        cnt_d            = CW'(WIDTH-2);
        state_d          = CONV;
`endif
      end
`ifndef GRAY_DECODE_FAST_EN
      CONV: begin
        bin_d[ci] = bin_q[ci+1] ^ gray_q[ci];
        if (cnt_q == '0) begin
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif
      DONE: if (out_ready) begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      bin_q       <= '0;
      out_valid_q <= 1'b0;
`ifndef GRAY_DECODE_FAST_EN
      cnt_q       <= '0;
      gray_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      bin_q       <= bin_d;
      out_valid_q <= out_valid_d;
`ifndef GRAY_DECODE_FAST_EN
      cnt_q       <= cnt_d;
      gray_q      <= gray_d;
`endif
    end
  end

endmodule

// File: tb/tb_gray_decode_arbiter.sv
// Bench for gray_decode_arbiter: directed scenarios plus random traffic, all
// scored by a monitor against a reference model (Gray decode by search,
// round-robin by pointer walk). Build with GRAY_DECODE_FAST_EN for the fast variant.
module tb_gray_decode_arbiter;
  localparam int W = 4;
  localparam int N = 4;
`ifdef GRAY_DECODE_FAST_EN
  localparam int LAT = 0;
`else
  localparam int LAT = W-1;
`endif

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_gray;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_bin;
  logic [1:0]     out_id;
  logic           busy;

  gray_decode_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_gray(req_gray),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_bin(out_bin), .out_id(out_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int id; int bin; int due; } exp_t;
  exp_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           mptr   = 0;
  logic [N-1:0] acc_mask = '0;

  // Binary value n whose Gray code n^(n>>1) equals g.
  function automatic int ref_bin(input int g);
    for (int n = 0; n < (1 << W); n++) if ((n ^ (n >> 1)) == g) return n;
    return -1;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Monitor: predicts grants, pushes expected results on accept, pops on output.
  initial forever begin
    int g;
    int idx;
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      chk("reset out_valid", int'(out_valid), 0);
      chk("reset busy", int'(busy), 0);
      chk("reset out_bin", int'(out_bin), 0);
      chk("reset out_id", int'(out_id), 0);
      exp_q.delete();
      mptr = 0;
      acc_mask = '0;
    end else begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        idx = (mptr + k) % N;
        if (g < 0 && req_valid[idx]) g = idx;
      end
      if (exp_q.size() != 0) begin
        acc_mask = '0;
        chk("busy while in flight", int'(busy), 1);
        chk("req_ready while busy", int'(req_ready), 0);
        if (cyc >= exp_q[0].due) begin
          chk("out_valid at/after latency", int'(out_valid), 1);
          chk("out_bin", int'(out_bin), exp_q[0].bin);
          chk("out_id", int'(out_id), exp_q[0].id);
          if (out_valid && out_ready) void'(exp_q.pop_front());
        end else begin
          chk("out_valid before latency", int'(out_valid), 0);
        end
      end else begin
        chk("busy idle", int'(busy), 0);
        chk("out_valid idle", int'(out_valid), 0);
        chk("req_ready grant", int'(req_ready), (g >= 0) ? (1 << g) : 0);
        acc_mask = req_valid & req_ready;
        if (g >= 0) begin
          e.id  = g;
          e.bin = ref_bin(int'(req_gray[g*W +: W]));
          e.due = cyc + 1 + LAT;
          exp_q.push_back(e);
          mptr = (g + 1) % N;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int i);
    for (int t = 0; t < 300; t++) begin
      step();
      if (acc_mask[i]) return;
    end
    $display("FAIL accept timeout requester=%0d actual=none expected=grant", i);
    $fatal(1, "accept timeout");
  endtask

  task automatic send(input int i, input logic [W-1:0] g);
    req_gray[i*W +: W] = g;
    req_valid[i] = 1'b1;
    wait_acc(i);
    req_valid[i] = 1'b0;
  endtask

  // All four requesters raised together; each drops once accepted.
  task automatic contend(input logic [N*W-1:0] words);
    logic [N-1:0] pend;
    req_gray  = words;
    req_valid = '1;
    pend      = '1;
    for (int t = 0; t < 300 && pend != '0; t++) begin
      step();
      for (int i = 0; i < N; i++) if (acc_mask[i]) begin
        req_valid[i] = 1'b0;
        pend[i] = 1'b0;
      end
    end
    if (pend != '0) begin
      $display("FAIL contention timeout actual=%0h expected=0", pend);
      $fatal(1, "contention timeout");
    end
  endtask

  initial begin
    logic [W-1:0] gw;
    rst_n = 1'b0; req_valid = '0; req_gray = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // single request: 1011 -> 1101, id 0
    send(0, 4'b1011);
    repeat (W + 2) step();

    // sweep of all Gray codes from requester 2
    for (int n = 0; n < (1 << W); n++) begin
      gw = W'(n ^ (n >> 1));
      send(2, gw);
    end
    repeat (W + 2) step();

    // contention: requester 3..0 words 0101/1111/1000/0110, then wrap to 0
    contend({4'b0101, 4'b1111, 4'b1000, 4'b0110});
    send(0, 4'b0110);
    repeat (W + 2) step();

    // back-pressure with a second requester waiting
    out_ready = 1'b0;
    send(0, 4'b1100);
    req_gray[1*W +: W] = 4'b0111;
    req_valid[1] = 1'b1;
    repeat (LAT + 10) step();
    out_ready = 1'b1;
    wait_acc(1);
    req_valid[1] = 1'b0;
    repeat (W + 2) step();

    // asynchronous reset in the second CONV cycle (DONE in the fast build)
    out_ready = 1'b0;
    send(1, 4'b0110);
    step();
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    contend({4'b0001, 4'b0011, 4'b0010, 4'b0110});
    send(3, 4'b0010);
    repeat (W + 2) step();

    // random traffic with random back-pressure and request withdrawal
    for (int t = 0; t < 1500; t++) begin
      step();
      out_ready = ($urandom_range(3) != 0);
      for (int i = 0; i < N; i++) begin
        if (acc_mask[i] || !req_valid[i]) begin
          if ($urandom_range(2) == 0) begin
            req_gray[i*W +: W] = W'($urandom_range((1 << W) - 1));
            req_valid[i] = 1'b1;
          end else begin
            req_valid[i] = 1'b0;
          end
        end else if ($urandom_range(15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end

    // drain
    req_valid = '0;
    out_ready = 1'b1;
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) step();
    if (exp_q.size() != 0) begin
      $display("FAIL drain timeout actual=%0d pending expected=0", exp_q.size());
      $fatal(1, "drain timeout");
    end
    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
